// File: rtl/pwm_fade_sched.sv
// ---------------------------------------------------------------------------
// pwm_fade_sched
//
// Scheduler between the PIO configuration registers and the PWM
// counter/compare datapath. Owns the period and duty values fed to the
// datapath. Those values change only on PERIOD_END, so the compare never
// glitches mid-period. Runs automatic duty fades (breathe, sawtooth) and
// toggles output enable from a debounced push button.
//
// Ports:
//   CLK         system clock
//   RST         synchronous active-high reset
//   PUSH        raw push button, active-low, asynchronous to CLK
//   CFG_PERIOD  requested PWM period
//   CFG_DUTY    requested duty for static mode
//   CFG_STEP    duty change per PWM period in fade modes
//   CFG_HOLD    extra periods to dwell at each extreme
//   CFG_MODE    00 static, 01 breathe, 10 sawtooth, 11 static
//   CFG_LOAD    one-cycle pulse, captures CFG_* into the shadow set
//   PERIOD_END  one-cycle pulse from the datapath at counter clear
//   PERIOD_OUT  active period (0 is driven as 1)
//   DUTY_OUT    active duty / compare value
//   ACTIVE      output enable state
//   STATE       FSM state, for debug
// ---------------------------------------------------------------------------
module pwm_fade_sched #(
    parameter int WIDTH      = 28,
    parameter int STEP_W     = 16,
    parameter int HOLD_W     = 8,
    parameter int DEB_CYCLES = 500000,
    parameter int RST_PERIOD = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PUSH,
    input  logic [WIDTH-1:0]  CFG_PERIOD,
    input  logic [WIDTH-1:0]  CFG_DUTY,
    input  logic [STEP_W-1:0] CFG_STEP,
    input  logic [HOLD_W-1:0] CFG_HOLD,
    input  logic [1:0]        CFG_MODE,
    input  logic              CFG_LOAD,
    input  logic              PERIOD_END,
    output logic [WIDTH-1:0]  PERIOD_OUT,
    output logic [WIDTH-1:0]  DUTY_OUT,
    output logic              ACTIVE,
    output logic [2:0]        STATE
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STATIC    = 3'd1,
        S_RAMP_UP   = 3'd2,
        S_HOLD_HIGH = 3'd3,
        S_RAMP_DOWN = 3'd4,
        S_HOLD_LOW  = 3'd5
    } state_t;

    localparam logic [1:0] MODE_BREATHE  = 2'b01;
    localparam logic [1:0] MODE_SAWTOOTH = 2'b10;

    // Arithmetic width wide enough for duty + step without overflow,
    // whichever of WIDTH / STEP_W is larger.
    localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    localparam int              DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // A zero period would stall the datapath counter; drive it as 1.
    function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] p);
        return (p == '0) ? WIDTH'(1) : p;
    endfunction

    function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] d,
                                                    input logic [WIDTH-1:0] p);
        return (d > p) ? p : d;
    endfunction

    function automatic logic is_fade(input logic [1:0] m);
        return (m == MODE_BREATHE) || (m == MODE_SAWTOOTH);
    endfunction

    // ------------------------------------------------------------------
    // Button: 2-FF synchroniser, level debouncer, press edge detect
    // ------------------------------------------------------------------
    logic             push_meta, push_sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_stable, deb_stable_d;
    logic             active_q;
    logic             press;

    assign press = deb_stable_d & ~deb_stable;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            push_meta    <= 1'b1;
            push_sync    <= 1'b1;
            deb_cnt      <= '0;
            deb_stable   <= 1'b1;
            deb_stable_d <= 1'b1;
            active_q     <= 1'b0;
        end else begin
            push_meta    <= PUSH;
            push_sync    <= push_meta;
            deb_stable_d <= deb_stable;
            if (push_sync != deb_stable) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_stable <= push_sync;
                    deb_cnt    <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
            // Only a press (stable 1->0) toggles; release is ignored.
            active_q <= active_q ^ press;
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active configuration sets
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  sh_period, sh_duty;
    logic [STEP_W-1:0] sh_step;
    logic [HOLD_W-1:0] sh_hold;
    logic [1:0]        sh_mode;
    logic              pending;

    logic [WIDTH-1:0]  act_period, act_duty;
    logic [STEP_W-1:0] act_step;
    logic [HOLD_W-1:0] act_hold;
    logic [1:0]        act_mode;

    logic apply;
    // Uses the shadow as it stood before any same-cycle CFG_LOAD capture.
    assign apply = PERIOD_END & pending;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_period  <= '0;
            sh_duty    <= '0;
            sh_step    <= '0;
            sh_hold    <= '0;
            sh_mode    <= 2'b00;
            pending    <= 1'b0;
            act_period <= WIDTH'(RST_PERIOD);
            act_duty   <= '0;
            act_step   <= '0;
            act_hold   <= '0;
            act_mode   <= 2'b00;
        end else begin
            if (apply) begin
                act_period <= sh_period;
                act_duty   <= sh_duty;
                act_step   <= sh_step;
                act_hold   <= sh_hold;
                act_mode   <= sh_mode;
            end
            if (CFG_LOAD) begin
                sh_period <= CFG_PERIOD;
                sh_duty   <= CFG_DUTY;
                sh_step   <= CFG_STEP;
                sh_hold   <= CFG_HOLD;
                sh_mode   <= CFG_MODE;
            end
            // A capture coinciding with an apply leaves new values pending.
            if (CFG_LOAD)
                pending <= 1'b1;
            else if (PERIOD_END)
                pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Fade FSM, evaluated only on PERIOD_END
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  duty_q, duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [WIDTH-1:0] period_eff;
    logic [AW-1:0]    duty_x, step_x, period_x, sum_x;

    assign period_eff = eff_period(act_period);
    assign duty_x     = AW'(duty_q);
    assign step_x     = AW'(act_step);
    assign period_x   = AW'(period_eff);
    assign sum_x      = duty_x + step_x;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path through
    // the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        if (PERIOD_END) begin
            if (apply) begin
                // Restart from IDLE on the new set; ACTIVE=0 forces duty 0.
                state_d = S_IDLE;
                hold_d  = '0;
                if (active_q && !is_fade(sh_mode))
                    duty_d = clamp_duty(sh_duty, eff_period(sh_period));
                else
                    duty_d = '0;
            end else if (!active_q) begin
                state_d = S_IDLE;
                duty_d  = '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (is_fade(act_mode)) begin
                            state_d = S_RAMP_UP;
                            duty_d  = '0;
                        end else begin
                            state_d = S_STATIC;
                            duty_d  = clamp_duty(act_duty, period_eff);
                        end
                    end
                    S_STATIC: begin
                        duty_d = clamp_duty(act_duty, period_eff);
                    end
                    S_RAMP_UP: begin
                        if (sum_x >= period_x) begin
                            duty_d  = period_eff;
                            hold_d  = act_hold;
                            state_d = S_HOLD_HIGH;
                        end else begin
                            duty_d = WIDTH'(sum_x);
                        end
                    end
                    S_HOLD_HIGH: begin
                        if (hold_q == '0) begin
                            if (act_mode == MODE_SAWTOOTH) begin
                                state_d = S_RAMP_UP;
                                duty_d  = '0;
                            end else begin
                                state_d = S_RAMP_DOWN;
                            end
                        end else begin
                            hold_d = hold_q - 1'b1;
                        end
                    end
                    S_RAMP_DOWN: begin
                        if (duty_x <= step_x) begin
                            duty_d  = '0;
                            hold_d  = act_hold;
                            state_d = S_HOLD_LOW;
                        end else begin
                            duty_d = WIDTH'(duty_x - step_x);
                        end
                    end
                    S_HOLD_LOW: begin
                        if (hold_q == '0)
                            state_d = S_RAMP_UP;
                        else
                            hold_d = hold_q - 1'b1;
                    end
                    default: begin
                        state_d = S_IDLE;
                        duty_d  = '0;
                    end
                endcase
            end
        end
    end

    assign PERIOD_OUT = period_eff;
    assign DUTY_OUT   = duty_q;
    assign ACTIVE     = active_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_pwm_fade_sched.sv
// ---------------------------------------------------------------------------
// tb_pwm_fade_sched
//
// Directed bench for pwm_fade_sched with WIDTH=8, DEB_CYCLES=4 and
// RST_PERIOD=200. Inputs change on the falling edge; outputs are sampled on
// the falling edge, half a cycle after the rising edge that updates them.
// ---------------------------------------------------------------------------
module tb_pwm_fade_sched;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 16;
    localparam int HOLD_W = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              PUSH;
    logic [WIDTH-1:0]  CFG_PERIOD;
    logic [WIDTH-1:0]  CFG_DUTY;
    logic [STEP_W-1:0] CFG_STEP;
    logic [HOLD_W-1:0] CFG_HOLD;
    logic [1:0]        CFG_MODE;
    logic              CFG_LOAD;
    logic              PERIOD_END;
    logic [WIDTH-1:0]  PERIOD_OUT;
    logic [WIDTH-1:0]  DUTY_OUT;
    logic              ACTIVE;
    logic [2:0]        STATE;

    int n_checks = 0;
    int n_pass   = 0;
    int toggles  = 0;
    logic active_prev = 1'b0;

    pwm_fade_sched #(
        .WIDTH      (WIDTH),
        .STEP_W     (STEP_W),
        .HOLD_W     (HOLD_W),
        .DEB_CYCLES (4),
        .RST_PERIOD (200)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PUSH       (PUSH),
        .CFG_PERIOD (CFG_PERIOD),
        .CFG_DUTY   (CFG_DUTY),
        .CFG_STEP   (CFG_STEP),
        .CFG_HOLD   (CFG_HOLD),
        .CFG_MODE   (CFG_MODE),
        .CFG_LOAD   (CFG_LOAD),
        .PERIOD_END (PERIOD_END),
        .PERIOD_OUT (PERIOD_OUT),
        .DUTY_OUT   (DUTY_OUT),
        .ACTIVE     (ACTIVE),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    // Count ACTIVE transitions just after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (ACTIVE !== active_prev) toggles = toggles + 1;
        active_prev = ACTIVE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass = n_pass + 1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_end();
        PERIOD_END = 1'b1;
        @(negedge CLK);
        PERIOD_END = 1'b0;
    endtask

    task automatic load_cfg(input logic [WIDTH-1:0] period, input logic [WIDTH-1:0] duty,
                            input logic [STEP_W-1:0] step, input logic [HOLD_W-1:0] hold,
                            input logic [1:0] mode);
        CFG_PERIOD = period;
        CFG_DUTY   = duty;
        CFG_STEP   = step;
        CFG_HOLD   = hold;
        CFG_MODE   = mode;
        CFG_LOAD   = 1'b1;
        @(negedge CLK);
        CFG_LOAD   = 1'b0;
    endtask

    // Hold the button low for n cycles, then release and let it settle.
    task automatic press_button(input int n);
        PUSH = 1'b0;
        cycles(n);
        PUSH = 1'b1;
        cycles(12);
    endtask

    // Breathe, period 100, step 30, hold 1, starting from IDLE.
    logic [7:0] br_duty [14] = '{0, 30, 60, 90, 100, 100, 100, 70, 40, 10, 0, 0, 0, 30};
    logic [2:0] br_state[14] = '{2, 2, 2, 2, 3, 3, 4, 4, 4, 4, 5, 5, 2, 2};
    // Sawtooth, same configuration.
    logic [7:0] sw_duty [8]  = '{0, 30, 60, 90, 100, 100, 0, 30};
    logic [2:0] sw_state[8]  = '{2, 2, 2, 2, 3, 3, 2, 2};

    initial begin
        RST        = 1'b1;
        PUSH       = 1'b1;
        CFG_PERIOD = '0;
        CFG_DUTY   = '0;
        CFG_STEP   = '0;
        CFG_HOLD   = '0;
        CFG_MODE   = 2'b00;
        CFG_LOAD   = 1'b0;
        PERIOD_END = 1'b0;
        cycles(3);
        RST = 1'b0;
        cycles(1);

        check("rst_period", 32'(PERIOD_OUT), 200);
        check("rst_duty",   32'(DUTY_OUT),   0);
        check("rst_active", 32'(ACTIVE),     0);
        check("rst_state",  32'(STATE),      0);

        // Glitch shorter than the debounce window is ignored.
        toggles = 0;
        press_button(3);
        check("short_press_active", 32'(ACTIVE), 0);
        check("short_press_toggles", 32'(toggles), 0);

        // Valid press toggles exactly once.
        press_button(6);
        check("press_active", 32'(ACTIVE), 1);
        check("press_toggles", 32'(toggles), 1);

        // Static mode: duty clamped to period.
        load_cfg(8'd100, 8'd150, 16'd30, 8'd1, 2'b00);
        pulse_end();
        check("static_apply_period", 32'(PERIOD_OUT), 100);
        check("static_apply_state",  32'(STATE),      0);
        pulse_end();
        check("static_duty",  32'(DUTY_OUT), 100);
        check("static_state", 32'(STATE),    1);
        cycles(5);
        check("static_hold_duty",  32'(DUTY_OUT), 100);
        check("static_hold_state", 32'(STATE),    1);

        // Breathe sequence.
        load_cfg(8'd100, 8'd0, 16'd30, 8'd1, 2'b01);
        pulse_end();
        check("breathe_apply_state", 32'(STATE),    0);
        check("breathe_apply_duty",  32'(DUTY_OUT), 0);
        for (int i = 0; i < 14; i++) begin
            pulse_end();
            check($sformatf("breathe_duty[%0d]", i),  32'(DUTY_OUT), 32'(br_duty[i]));
            check($sformatf("breathe_state[%0d]", i), 32'(STATE),    32'(br_state[i]));
            cycles(2);
        end

        // Sawtooth sequence.
        load_cfg(8'd100, 8'd0, 16'd30, 8'd1, 2'b10);
        pulse_end();
        check("saw_apply_state", 32'(STATE), 0);
        for (int i = 0; i < 8; i++) begin
            pulse_end();
            check($sformatf("saw_duty[%0d]", i),  32'(DUTY_OUT), 32'(sw_duty[i]));
            check($sformatf("saw_state[%0d]", i), 32'(STATE),    32'(sw_state[i]));
        end

        // CFG_LOAD coinciding with PERIOD_END: capture only, apply later.
        CFG_PERIOD = 8'd50;
        CFG_LOAD   = 1'b1;
        PERIOD_END = 1'b1;
        @(negedge CLK);
        CFG_LOAD   = 1'b0;
        PERIOD_END = 1'b0;
        check("same_cycle_period", 32'(PERIOD_OUT), 100);
        cycles(2);
        pulse_end();
        check("deferred_period", 32'(PERIOD_OUT), 50);
        check("deferred_state",  32'(STATE),      0);
        pulse_end();
        pulse_end();
        check("pre_off_duty", 32'(DUTY_OUT), 30);

        // Second press disables; DUTY_OUT drops at next PERIOD_END only.
        press_button(6);
        check("press2_active", 32'(ACTIVE), 0);
        check("press2_duty_held", 32'(DUTY_OUT), 30);
        pulse_end();
        check("off_duty",  32'(DUTY_OUT), 0);
        check("off_state", 32'(STATE),    0);

        // A programmed period of 0 is driven as 1.
        load_cfg(8'd0, 8'd0, 16'd0, 8'd0, 2'b00);
        pulse_end();
        check("zero_period", 32'(PERIOD_OUT), 1);

        // Reset in the middle of RAMP_DOWN.
        press_button(6);
        check("press3_active", 32'(ACTIVE), 1);
        load_cfg(8'd100, 8'd0, 16'd30, 8'd1, 2'b01);
        pulse_end();
        repeat (8) pulse_end();
        check("pre_rst_state", 32'(STATE),    4);
        check("pre_rst_duty",  32'(DUTY_OUT), 70);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_period", 32'(PERIOD_OUT), 200);
        check("mid_rst_duty",   32'(DUTY_OUT),   0);
        check("mid_rst_active", 32'(ACTIVE),     0);
        check("mid_rst_state",  32'(STATE),      0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_fade_sched.md
Name: pwm_fade_sched

Overview:
- Scheduler sitting between the Nios-side PIO configuration registers and the PWM counter/compare datapath.
- Owns the period and duty values driven into the datapath and changes them only at PWM period boundaries (glitch-free).
- Sequences automatic duty fades: static, breathe, or sawtooth.
- A debounced push button toggles output enable.

Parameters:
- WIDTH, 28, width of period/duty values
- STEP_W, 16, width of the per-period duty increment
- HOLD_W, 8, width of the dwell counter
- DEB_CYCLES, 500000, consecutive stable samples required to accept a button level (10 ms at 50 MHz)
- RST_PERIOD, 50000, PERIOD_OUT value after reset

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- PUSH  in  1  raw push button, active-low, asynchronous to CLK
- CFG_PERIOD  in  WIDTH  requested PWM period
- CFG_DUTY  in  WIDTH  requested duty for static mode
- CFG_STEP  in  STEP_W  duty change per PWM period in fade modes
- CFG_HOLD  in  HOLD_W  number of extra periods to dwell at each extreme
- CFG_MODE  in  2  00 static, 01 breathe, 10 sawtooth, 11 reserved (treated as static)
- CFG_LOAD  in  1  one-cycle pulse; captures all CFG_* into the shadow set
- PERIOD_END  in  1  one-cycle pulse from the datapath when its counter clears
- PERIOD_OUT  out  WIDTH  active period to the datapath
- DUTY_OUT  out  WIDTH  active duty (compare value) to the datapath
- ACTIVE  out  1  output enable state
- STATE  out  3  FSM state, for debug

Behaviour:
- Reset (RST=1 at a CLK edge):
  - PERIOD_OUT=RST_PERIOD, DUTY_OUT=0, ACTIVE=0, STATE=IDLE(0).
  - Shadow set cleared (mode static); pending=0; hold counter 0.
  - Debouncer stable level = 1 (released); synchroniser cleared to 1.
  - Reset mid-fade abandons the sequence at once, with no waiting for PERIOD_END.
- Shadow/pending:
  - CFG_LOAD captures CFG_* into the shadow set and sets pending.
  - At PERIOD_END with pending=1, the shadow is copied to the active set, PERIOD_OUT updates, pending clears, and the FSM restarts from its mode's entry state with DUTY_OUT=0 (static: DUTY_OUT=min(duty,period)).
  - If CFG_LOAD and PERIOD_END occur in the same cycle, the apply uses the pre-capture shadow, the new values are captured, and pending stays 1.
  - An active period of 0 is driven as 1.
- Button:
  - 2-FF synchroniser feeds a counter. The stable level changes after DEB_CYCLES consecutive samples differing from it; any matching sample resets the counter.
  - Stable 1->0 (press) toggles ACTIVE on the next cycle. Release has no effect.
- DUTY_OUT and STATE change only in cycles with PERIOD_END=1; there is no other update path except reset.
- FSM states: IDLE=0, STATIC=1, RAMP_UP=2, HOLD_HIGH=3, RAMP_DOWN=4, HOLD_LOW=5. Evaluated only on PERIOD_END:
  - ACTIVE=0 -> IDLE, DUTY_OUT=0 (from any state).
  - IDLE with ACTIVE=1 -> STATIC (static mode) or RAMP_UP with duty 0 (fade modes).
  - STATIC: DUTY_OUT=min(active duty, period).
  - RAMP_UP: sum = duty+step computed at WIDTH+1 bits. If sum>=period: DUTY_OUT=period, load hold counter with CFG_HOLD, -> HOLD_HIGH. Else DUTY_OUT=sum.
  - HOLD_HIGH: if counter=0 -> RAMP_DOWN (breathe), or -> RAMP_UP with DUTY_OUT=0 (sawtooth). Else decrement.
  - RAMP_DOWN: if duty<=step: DUTY_OUT=0, load hold counter, -> HOLD_LOW. Else duty-step.
  - HOLD_LOW: if counter=0 -> RAMP_UP. Else decrement.
- Step 0 holds duty constant in ramp states; this is legal and must not hang the hold logic.
- Apply (pending) takes priority over FSM advance in the same PERIOD_END cycle. ACTIVE=0 takes priority over both for DUTY_OUT; the apply still updates the active set.

Test Plan:
- Reset with WIDTH=8: PERIOD_OUT=RST_PERIOD, DUTY_OUT=0, ACTIVE=0, STATE=0. Set RST_PERIOD=200 in the bench.
- DEB_CYCLES=4:
  - PUSH low 3 cycles then high -> ACTIVE stays 0.
  - PUSH low 6 cycles -> ACTIVE=1 exactly once.
  - A second press -> ACTIVE=0 and DUTY_OUT=0 at the next PERIOD_END.
- Static: load period=100, duty=150, mode 00, ACTIVE=1, pulse PERIOD_END.
  - PERIOD_OUT=100 and STATE=IDLE after the first PERIOD_END.
  - DUTY_OUT=100 after the second PERIOD_END.
  - No change between pulses.
- Breathe: period=100, step=30, hold=1 -> DUTY_OUT per PERIOD_END: 0,30,60,90,100(HOLD_HIGH),100,100(->RAMP_DOWN),70,40,10,0(HOLD_LOW),0,0,30.
- Sawtooth, same config -> after HOLD_HIGH expires, DUTY_OUT=0 in RAMP_UP, then 30.
- CFG_LOAD (period 50) and PERIOD_END in the same cycle -> PERIOD_OUT unchanged that cycle, becomes 50 at the next PERIOD_END.
- Assert RST during RAMP_DOWN -> all outputs return to reset values the next cycle.
